// File: rtl/cache_bus_pkg.sv
// Shared definitions for the A1/D1/C1 CPU-to-cache command bus: command codes,
// bus widths and the bus master state encoding.
package cache_bus_pkg;

  localparam int C1_W   = 3;
  localparam int BEAT_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_READ8      = 3'd1,
    CMD_READ16     = 3'd2,
    CMD_READ32     = 3'd3,
    CMD_INVALIDATE = 3'd4,
    CMD_WRITE8     = 3'd5,
    CMD_WRITE16    = 3'd6,
    CMD_WRITE32    = 3'd7
  } c1_cmd_e;

  // The cache answers with the same code the initiator uses for WRITE32.
  localparam c1_cmd_e CMD_RESPONSE = CMD_WRITE32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_CMD2,
    ST_TURN,
    ST_WAIT,
    ST_DATA2,
    ST_DONE
  } state_e;

  function automatic logic is_write(input c1_cmd_e op);
    return (op == CMD_WRITE8) || (op == CMD_WRITE16) || (op == CMD_WRITE32);
  endfunction

endpackage

// File: rtl/bus_tristate_drv.sv
// Output-enable muxing for the shared C1/D1 lines; also returns what is seen on
// the lines so the owner can sample the other side's drive.
module bus_tristate_drv #(
  parameter int DATA_W = 16,
  parameter int C_W    = 3
) (
  input  logic              cmd_en,
  input  logic [C_W-1:0]    cmd_drv,
  input  logic              data_en,
  input  logic [DATA_W-1:0] data_drv,
  output logic [C_W-1:0]    cmd_sampled,
  output logic [DATA_W-1:0] data_sampled,
  inout  wire  [C_W-1:0]    cmd_bus,
  inout  wire  [DATA_W-1:0] data_bus
);

  assign cmd_bus = cmd_en ? cmd_drv : {C_W{1'bz}};

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data_bit
    assign data_bus[gi] = data_en ? data_drv[gi] : 1'bz;
  end

  assign cmd_sampled  = cmd_bus;
  assign data_sampled = data_bus;

endmodule

// File: rtl/cpu_bus_master.sv
// Initiator for the A1/D1/C1 cache command bus: one core request per bus transaction.
// Define CPU_BUS_MASTER_TIMEOUT_EN to bound the RESPONSE wait to TIMEOUT cycles.
module cpu_bus_master
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] A1,
  inout  wire  [DATA_W-1:0] D1,
  inout  wire  [2:0]        C1
);

  state_e              state_reg;
  c1_cmd_e             op_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         rdata_reg;
  logic                err_reg;
  logic [ADDR_W-1:0]   a1_reg;
  logic                req_ready_reg;
  logic                rsp_valid_reg;
  logic                rsp_err_reg;
  logic [31:0]         rsp_rdata_reg;
  logic                cmd_en_reg;
  logic [2:0]          cmd_drv_reg;
  logic                data_en_reg;
  logic [DATA_W-1:0]   data_drv_reg;
  logic [2:0]          cmd_sampled;
  logic [DATA_W-1:0]   data_sampled;
`ifdef CPU_BUS_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    wait_cnt_reg;
`endif

  bus_tristate_drv #(.DATA_W(DATA_W), .C_W(3)) u_drv (
    .cmd_en       (cmd_en_reg),
    .cmd_drv      (cmd_drv_reg),
    .data_en      (data_en_reg),
    .data_drv     (data_drv_reg),
    .cmd_sampled  (cmd_sampled),
    .data_sampled (data_sampled),
    .cmd_bus      (C1),
    .data_bus     (D1)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      op_reg        <= CMD_NOP;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      a1_reg        <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      cmd_en_reg    <= 1'b1;
      cmd_drv_reg   <= CMD_NOP;
      data_en_reg   <= 1'b0;
      data_drv_reg  <= '0;
`ifdef CPU_BUS_MASTER_TIMEOUT_EN
      wait_cnt_reg  <= '0;
`endif
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && req_ready_reg) begin
            if (c1_cmd_e'(req_op) == CMD_NOP) begin
              // Illegal op: answer at once with an error, bus untouched.
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else begin
              op_reg        <= c1_cmd_e'(req_op);
              wdata_reg     <= req_wdata;
              a1_reg        <= req_addr;
              rdata_reg     <= '0;
              err_reg       <= 1'b0;
              req_ready_reg <= 1'b0;
              cmd_drv_reg   <= req_op;
              data_drv_reg  <= DATA_W'(req_wdata[15:0]);
              data_en_reg   <= is_write(c1_cmd_e'(req_op));
              state_reg     <= ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (op_reg == CMD_WRITE32) begin
            data_drv_reg <= DATA_W'(wdata_reg[31:16]);
            state_reg    <= ST_CMD2;
          end else begin
            cmd_en_reg  <= 1'b0;
            data_en_reg <= 1'b0;
            state_reg   <= ST_TURN;
          end
        end
        ST_CMD2: begin
          cmd_en_reg  <= 1'b0;
          data_en_reg <= 1'b0;
          state_reg   <= ST_TURN;
        end
        ST_TURN: begin
`ifdef CPU_BUS_MASTER_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (c1_cmd_e'(cmd_sampled) == CMD_RESPONSE) begin
            case (op_reg)
              CMD_READ8:              rdata_reg       <= 32'(data_sampled[7:0]);
              CMD_READ16, CMD_READ32: rdata_reg[15:0] <= 16'(data_sampled);
              default:                rdata_reg       <= '0;
            endcase
            if (op_reg == CMD_READ32) begin
              state_reg <= ST_DATA2;
            end else begin
              cmd_en_reg  <= 1'b1;
              cmd_drv_reg <= CMD_NOP;
              state_reg   <= ST_DONE;
            end
          end
`ifdef CPU_BUS_MASTER_TIMEOUT_EN
          else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            err_reg     <= 1'b1;
            rdata_reg   <= '0;
            cmd_en_reg  <= 1'b1;
            cmd_drv_reg <= CMD_NOP;
            state_reg   <= ST_DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end
        ST_DATA2: begin
          rdata_reg[31:16] <= 16'(data_sampled);
          cmd_en_reg       <= 1'b1;
          cmd_drv_reg      <= CMD_NOP;
          state_reg        <= ST_DONE;
        end
        ST_DONE: begin
          rsp_valid_reg <= 1'b1;
          rsp_rdata_reg <= rdata_reg;
          rsp_err_reg   <= err_reg;
          req_ready_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign A1        = a1_reg;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Self-checking bench for cpu_bus_master: a cycle-counting cache model answers on
// C1/D1 and expected results are derived from the command rules.
module tb_cpu_bus_master;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [17:0] A1;
  wire  [15:0] D1;
  wire  [2:0]  C1;

  logic        cache_en = 1'b0;
  logic [2:0]  cache_c  = '0;
  logic [15:0] cache_d  = '0;
  assign C1 = cache_en ? cache_c : 3'bz;
  assign D1 = cache_en ? cache_d : 16'bz;

  int n_cmp = 0;
  int n_bad = 0;

  // observations of the most recent transaction
  int          obs_rsp_k;
  logic        obs_accept_ready, obs_ready_low, obs_ready_at_rsp, obs_err;
  logic [31:0] obs_rdata;
  logic [2:0]  obs_cmd_c1, obs_cmd2_c1, obs_turn_c1;
  logic [15:0] obs_cmd_d1, obs_cmd2_d1, obs_turn_d1;
  logic [17:0] obs_cmd_a1, obs_done_a1;

  always #5 CLK = ~CLK;

  cpu_bus_master #(.ADDR_W(18), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .A1(A1), .D1(D1), .C1(C1)
  );

  function automatic logic [31:0] exp_rdata(input logic [2:0] op, input logic [15:0] b1,
                                            input logic [15:0] b2);
    case (op)
      3'd1:    return {24'd0, b1[7:0]};
      3'd2:    return {16'd0, b1};
      3'd3:    return {b2, b1};
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input int w);
    return 4 + w + ((op == 3'd7) ? 1 : 0) + ((op == 3'd3) ? 1 : 0);
  endfunction

  // Issue one request; the cache model answers RESPONSE in WAIT cycle w (0 = never).
  task automatic run_txn(input logic [2:0] op, input logic [17:0] addr, input logic [31:0] wdata,
                         input int w, input logic [15:0] b1, input logic [15:0] b2, input int limit);
    int t, resp_k;
    logic [17:0] prev_a1;
    @(negedge CLK);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    obs_accept_ready = req_ready;
    t = 2 + ((op == 3'd7) ? 1 : 0);
    resp_k = t + w;
    obs_rsp_k = -1; obs_ready_low = 1'b1; prev_a1 = A1;
    for (int k = 1; k <= limit && obs_rsp_k < 0; k++) begin
      @(posedge CLK); #1;
      req_valid = 1'b0;
      cache_en = 1'b0;
      if (k == t) begin
        cache_en = 1'b1; cache_c = 3'd0; cache_d = 16'd0;
      end else if (k > t) begin
        if (w > 0 && k == resp_k) begin
          cache_en = 1'b1; cache_c = 3'd7; cache_d = b1;
        end else if (w > 0 && op == 3'd3 && k == resp_k + 1) begin
          cache_en = 1'b1; cache_c = 3'd7; cache_d = b2;
        end else if ((w > 0 && k < resp_k) || (w == 0 && k <= t + TMO)) begin
          cache_en = 1'b1; cache_c = 3'($urandom_range(0, 6)); cache_d = 16'($urandom);
        end
      end
      @(negedge CLK);
      if (k == 1) begin obs_cmd_c1 = C1; obs_cmd_d1 = D1; obs_cmd_a1 = A1; end
      if (k == 2 && op == 3'd7) begin obs_cmd2_c1 = C1; obs_cmd2_d1 = D1; end
      if (k == t) begin obs_turn_c1 = C1; obs_turn_d1 = D1; end
      if (rsp_valid) begin
        obs_rsp_k = k; obs_rdata = rsp_rdata; obs_err = rsp_err;
        obs_ready_at_rsp = req_ready; obs_done_a1 = prev_a1;
      end else if (req_ready) begin
        obs_ready_low = 1'b0;
      end
      prev_a1 = A1;
    end
    cache_en = 1'b0;
    $display("txn op=%0d addr=%05h wdata=%08h w=%0d rsp_at=%0d rdata=%08h err=%b",
             op, addr, wdata, w, obs_rsp_k, obs_rdata, obs_err);
  endtask

  task automatic test_reset();
    Reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", rsp_err); end
    n_cmp++; if (A1 !== 18'd0) begin n_bad++; $display("FAIL reset_a1 got %h want 0", A1); end
    n_cmp++; if (C1 !== 3'd0) begin n_bad++; $display("FAIL reset_c1 got %h want 0", C1); end
  endtask

  task automatic test_read16();
    run_txn(3'd2, 18'h00123, 32'd0, 4, 16'hBEEF, 16'h0, 40);
    n_cmp++; if (obs_cmd_a1 !== 18'h00123) begin n_bad++; $display("FAIL rd16_a1 got %h want 00123", obs_cmd_a1); end
    n_cmp++; if (obs_cmd_c1 !== 3'd2) begin n_bad++; $display("FAIL rd16_c1 got %0d want 2", obs_cmd_c1); end
    n_cmp++; if (obs_rsp_k != 8) begin n_bad++; $display("FAIL rd16_latency got %0d want 8", obs_rsp_k); end
    n_cmp++; if (obs_rdata !== 32'h0000BEEF) begin n_bad++; $display("FAIL rd16_rdata got %h want 0000beef", obs_rdata); end
    n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL rd16_err got %b want 0", obs_err); end
  endtask

  task automatic test_write32();
    run_txn(3'd7, 18'h2AAAA, 32'hCAFEBABE, 2, 16'h1234, 16'h0, 40);
    n_cmp++; if (obs_cmd_c1 !== 3'd7) begin n_bad++; $display("FAIL wr32_cmd_c1 got %0d want 7", obs_cmd_c1); end
    n_cmp++; if (obs_cmd_d1 !== 16'hBABE) begin n_bad++; $display("FAIL wr32_cmd_d1 got %h want babe", obs_cmd_d1); end
    n_cmp++; if (obs_cmd2_c1 !== 3'd7) begin n_bad++; $display("FAIL wr32_cmd2_c1 got %0d want 7", obs_cmd2_c1); end
    n_cmp++; if (obs_cmd2_d1 !== 16'hCAFE) begin n_bad++; $display("FAIL wr32_cmd2_d1 got %h want cafe", obs_cmd2_d1); end
    n_cmp++; if (obs_turn_c1 !== 3'd0 || obs_turn_d1 !== 16'd0) begin
      n_bad++; $display("FAIL wr32_turn_released got c1=%h d1=%h want 0/0", obs_turn_c1, obs_turn_d1); end
    n_cmp++; if (obs_rsp_k != 7) begin n_bad++; $display("FAIL wr32_latency got %0d want 7", obs_rsp_k); end
    n_cmp++; if (obs_rdata !== 32'd0 || obs_err !== 1'b0) begin
      n_bad++; $display("FAIL wr32_rsp got rdata=%h err=%b want 0/0", obs_rdata, obs_err); end
  endtask

  task automatic test_read32();
    run_txn(3'd3, 18'h00F00, 32'd0, 1, 16'h1111, 16'h2222, 40);
    n_cmp++; if (obs_rdata !== 32'h22221111) begin n_bad++; $display("FAIL rd32_rdata got %h want 22221111", obs_rdata); end
    n_cmp++; if (obs_rsp_k != 6) begin n_bad++; $display("FAIL rd32_latency got %0d want 6", obs_rsp_k); end
  endtask

  task automatic test_read8();
    run_txn(3'd1, 18'h00042, 32'd0, 2, 16'hA5C3, 16'h0, 40);
    n_cmp++; if (obs_rdata !== 32'h000000C3) begin n_bad++; $display("FAIL rd8_rdata got %h want 000000c3", obs_rdata); end
  endtask

  task automatic test_illegal_op();
    logic [17:0] a_before;
    @(negedge CLK);
    a_before = A1;
    req_valid = 1'b1; req_op = 3'd0; req_addr = 18'h3FFFF; req_wdata = 32'hFFFFFFFF;
    @(posedge CLK); #1 req_valid = 1'b0;
    @(negedge CLK);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      n_bad++; $display("FAIL nop_rsp got valid=%b err=%b want 1/1", rsp_valid, rsp_err); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL nop_rdata got %h want 0", rsp_rdata); end
    n_cmp++; if (A1 !== a_before || C1 !== 3'd0) begin
      n_bad++; $display("FAIL nop_bus got a1=%h c1=%h want %h/0", A1, C1, a_before); end
    @(negedge CLK);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL nop_pulse got %b want 0", rsp_valid); end
    $display("txn op=0 addr=3ffff illegal, single error pulse expected");
  endtask

  task automatic test_random();
    logic [2:0] op; logic [17:0] addr; logic [31:0] wd; logic [15:0] b1, b2; int w;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(1, 7)); addr = 18'($urandom); wd = $urandom;
      b1 = 16'($urandom); b2 = 16'($urandom); w = $urandom_range(1, 4);
      run_txn(op, addr, wd, w, b1, b2, 40);
      n_cmp++; if (obs_accept_ready !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_accept_ready got %b want 1", i, obs_accept_ready); end
      n_cmp++; if (obs_rsp_k != exp_latency(op, w)) begin
        n_bad++; $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", i, op, obs_rsp_k, exp_latency(op, w)); end
      n_cmp++; if (obs_rdata !== exp_rdata(op, b1, b2) || obs_err !== 1'b0) begin
        n_bad++; $display("FAIL rnd%0d_rsp op=%0d got %h/%b want %h/0", i, op, obs_rdata, obs_err, exp_rdata(op, b1, b2)); end
      n_cmp++; if (obs_cmd_c1 !== op || obs_cmd_a1 !== addr || obs_done_a1 !== addr) begin
        n_bad++; $display("FAIL rnd%0d_cmd got c1=%0d a1=%h done_a1=%h want %0d/%h", i, obs_cmd_c1, obs_cmd_a1, obs_done_a1, op, addr); end
      if (op >= 3'd5) begin
        n_cmp++; if (obs_cmd_d1 !== wd[15:0]) begin n_bad++; $display("FAIL rnd%0d_wdata_lo got %h want %h", i, obs_cmd_d1, wd[15:0]); end
      end
      n_cmp++; if (obs_turn_c1 !== 3'd0 || obs_turn_d1 !== 16'd0) begin
        n_bad++; $display("FAIL rnd%0d_turn got c1=%h d1=%h want 0/0", i, obs_turn_c1, obs_turn_d1); end
      n_cmp++; if (obs_ready_low !== 1'b1 || obs_ready_at_rsp !== 1'b1) begin
        n_bad++; $display("FAIL rnd%0d_ready got busy_low=%b at_rsp=%b want 1/1", i, obs_ready_low, obs_ready_at_rsp); end
      @(negedge CLK);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_pulse got %b want 0", i, rsp_valid); end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    run_txn(3'd2, 18'h01555, 32'd0, 0, 16'h0, 16'h0, 4);
    @(posedge CLK); #1;
    Reset = 1'b1; cache_en = 1'b0;
    @(posedge CLK); #1 Reset = 1'b0;
    @(negedge CLK);
    n_cmp++; if (req_ready !== 1'b1 || C1 !== 3'd0 || A1 !== 18'd0) begin
      n_bad++; $display("FAIL rstwait_idle got ready=%b c1=%h a1=%h want 1/0/0", req_ready, C1, A1); end
    seen = 1'b0;
    repeat (10) begin @(negedge CLK); if (rsp_valid) seen = 1'b1; end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL rstwait_no_rsp got rsp_valid=1 want none"); end
  endtask

  task automatic test_timeout();
`ifdef CPU_BUS_MASTER_TIMEOUT_EN
    run_txn(3'd1, 18'h00777, 32'd0, 0, 16'h0, 16'h0, 30);
    n_cmp++; if (obs_rsp_k != 4 + TMO) begin n_bad++; $display("FAIL tmo_latency got %0d want %0d", obs_rsp_k, 4 + TMO); end
    n_cmp++; if (obs_err !== 1'b1 || obs_rdata !== 32'd0) begin
      n_bad++; $display("FAIL tmo_rsp got err=%b rdata=%h want 1/0", obs_err, obs_rdata); end
    n_cmp++; if (obs_done_a1 !== 18'h00777) begin n_bad++; $display("FAIL tmo_done_a1 got %h want 00777", obs_done_a1); end
`else
    run_txn(3'd1, 18'h00777, 32'd0, 0, 16'h0, 16'h0, 1000);
    n_cmp++; if (obs_rsp_k != -1) begin n_bad++; $display("FAIL notmo_hang got rsp at %0d want none", obs_rsp_k); end
    @(posedge CLK); #1 Reset = 1'b1;
    @(posedge CLK); #1 Reset = 1'b0;
`endif
    @(negedge CLK);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL tmo_ready got %b want 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_read16();
    test_write32();
    test_read32();
    test_read8();
    test_illegal_op();
    test_random();
    test_reset_mid_wait();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
